// File: rtl/dmac_arb_pkg.sv
// rtl/dmac_arb_pkg.sv - shared types and helpers for the DMA channel priority arbiter
package dmac_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        REL   = 2'd3
    } state_t;

    localparam int NUM_CH_MAX  = 16;
    localparam int IDX_W_MAX   = 4;
    // Key = {req, prio, rr}: the two extra bits on top of the priority field.
    localparam int KEY_EXTRA_W = 2;

    function automatic logic [NUM_CH_MAX-1:0] onehot(input logic [IDX_W_MAX-1:0] idx);
        logic [NUM_CH_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dmac_ch_prio_arbiter_maxsel.sv
// rtl/dmac_ch_prio_arbiter_maxsel.sv - combinational max-key select, ties resolve to the lowest index
module dmac_ch_prio_arbiter_maxsel #(
    parameter int WIDTH       = 5,
    parameter int NUM_INPUTS  = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic [NUM_INPUTS*WIDTH-1:0] a,
    output logic [INDEX_WIDTH-1:0]      index
);

    logic [WIDTH-1:0] best;

    // Strict greater-than keeps the earlier (lower) index on equal keys.
    always_comb begin
        best  = a[WIDTH-1:0];
        index = '0;
        for (int i = 1; i < NUM_INPUTS; i++) begin
            if (a[i*WIDTH +: WIDTH] > best) begin
                best  = a[i*WIDTH +: WIDTH];
                index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/dmac_ch_prio_arbiter.sv
// rtl/dmac_ch_prio_arbiter.sv - DMA channel arbiter: priority first, round-robin among equals, held grant
module dmac_ch_prio_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int PRIO_W    = 3,
    parameter int IDX_W     = 3,
    parameter int GRANT_MAX = 255
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic                     arb_en,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*PRIO_W-1:0] ch_prio,
    input  logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     grant_vld,
    output logic                     grant_tmo
);

    localparam int KEY_W = PRIO_W + KEY_EXTRA_W;
    localparam int CNT_W = (GRANT_MAX > 0) ? $clog2(GRANT_MAX + 1) : 1;

    state_t                  state_q, state_d;
    logic [NUM_CH*KEY_W-1:0] key_q, key_d, cur_keys;
    logic [IDX_W-1:0]        last_idx_q, last_idx_d;
    logic [CNT_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [NUM_CH-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic                    grant_vld_q, grant_vld_d;
    logic                    grant_tmo_q, grant_tmo_d;
    logic [IDX_W-1:0]        win_idx;
    logic                    start_hit, rel_hit, tmo_hit;

    // rr bit lifts channels after the last winner above those at or before it.
    always_comb begin
        cur_keys = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_keys[i*KEY_W +: KEY_W] = {ch_req[i], ch_prio[i*PRIO_W +: PRIO_W],
                                          (IDX_W'(i) > last_idx_q)};
        end
    end

    dmac_ch_prio_arbiter_maxsel #(
        .WIDTH       (KEY_W),
        .NUM_INPUTS  (NUM_CH),
        .INDEX_WIDTH (IDX_W)
    ) u_maxsel (
        .a     (key_q),
        .index (win_idx)
    );

    assign start_hit = arb_en && (|ch_req);
    assign rel_hit   = ch_done[grant_idx_q] || !ch_req[grant_idx_q];
    assign tmo_hit   = (GRANT_MAX != 0) && (hold_cnt_q == CNT_W'(GRANT_MAX - 1));

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_hit) state_d = ARB;
            ARB:     state_d = ch_req[win_idx] ? GRANT : IDLE;
            GRANT:   if (rel_hit || tmo_hit) state_d = REL;
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_d       = key_q;
        last_idx_d  = last_idx_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        grant_vld_d = grant_vld_q;
        grant_tmo_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_hit) key_d = cur_keys;
            end
            ARB: begin
                if (ch_req[win_idx]) begin
                    grant_d     = NUM_CH'(onehot(IDX_W_MAX'(win_idx)));
                    grant_idx_d = win_idx;
                    grant_vld_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (hold_cnt_q != {CNT_W{1'b1}}) hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (rel_hit || tmo_hit) begin
                    grant_d     = '0;
                    grant_vld_d = 1'b0;
                    grant_tmo_d = tmo_hit && !rel_hit;
                end
            end
            REL: begin
                last_idx_d = grant_idx_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            key_q       <= '0;
            last_idx_q  <= IDX_W'(NUM_CH - 1);
            hold_cnt_q  <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            grant_tmo_q <= 1'b0;
        end else begin
            key_q       <= key_d;
            last_idx_q  <= last_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            grant_vld_q <= grant_vld_d;
            grant_tmo_q <= grant_tmo_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign grant_vld = grant_vld_q;
    assign grant_tmo = grant_tmo_q;

endmodule
